// File: rtl/jk_ff_monitor.sv
// Observational checker for a JK flip-flop: compares each clocked transition of Q/Qbar
// against the JK truth table using the previous edge's observed samples.
module jk_ff_monitor #(
    parameter int CNT_W       = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic             J,
    input  logic             K,
    input  logic             Q,
    input  logic             Qbar,
    output logic [CNT_W-1:0] checked_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic             err,
    output logic             err_pulse,
    output logic             synced
);

    // state  | meaning
    // IDLE   | monitoring off, waiting for en
    // PRIME  | first enabled edge: capture J/K/Q, no check
    // CHECK  | one check per edge, recapture samples
    // HALT   | frozen after an error (STOP_ON_ERR=1), left via clear or reset
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_CHECK = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             j_smp_q, j_smp_d;
    logic             k_smp_q, k_smp_d;
    logic             q_smp_q, q_smp_d;
    logic [CNT_W-1:0] checked_q, checked_d;
    logic [CNT_W-1:0] errcnt_q, errcnt_d;
    logic [CNT_W-1:0] first_q, first_d;
    logic             err_q, err_d;
    logic             pulse_q, pulse_d;
    logic             q_exp;
    logic             chk_fail;

    always_comb begin
        unique case ({j_smp_q, k_smp_q})
            2'b00:   q_exp = q_smp_q;
            2'b01:   q_exp = 1'b0;
            2'b10:   q_exp = 1'b1;
            default: q_exp = ~q_smp_q;
        endcase
        // Case-inequality so that X/Z on Q or Qbar is reported as a failure.
        chk_fail = (Q !== q_exp) || (Qbar !== ~Q);
    end

    always_comb begin
        state_d   = state_q;
        j_smp_d   = j_smp_q;
        k_smp_d   = k_smp_q;
        q_smp_d   = q_smp_q;
        checked_d = checked_q;
        errcnt_d  = errcnt_q;
        first_d   = first_q;
        err_d     = err_q;
        pulse_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_PRIME;
            end
            ST_PRIME: begin
                j_smp_d = J;
                k_smp_d = K;
                q_smp_d = Q;
                state_d = en ? ST_CHECK : ST_IDLE;
            end
            ST_CHECK: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else begin
                    j_smp_d = J;
                    k_smp_d = K;
                    q_smp_d = Q;
                    if (checked_q != CNT_MAX) checked_d = checked_q + CNT_ONE;
                    if (chk_fail) begin
                        if (errcnt_q != CNT_MAX) errcnt_d = errcnt_q + CNT_ONE;
                        if (!err_q) first_d = checked_q;
                        err_d   = 1'b1;
                        pulse_d = 1'b1;
                        if (STOP_ON_ERR) state_d = ST_HALT;
                    end
                end
            end
            default: begin
            end
        endcase

        // Clear discards whatever the CHECK branch computed this edge.
        if (clear) begin
            state_d   = ST_IDLE;
            checked_d = '0;
            errcnt_d  = '0;
            first_d   = '0;
            err_d     = 1'b0;
            pulse_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            j_smp_q   <= 1'b0;
            k_smp_q   <= 1'b0;
            q_smp_q   <= 1'b0;
            checked_q <= '0;
            errcnt_q  <= '0;
            first_q   <= '0;
            err_q     <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            j_smp_q   <= j_smp_d;
            k_smp_q   <= k_smp_d;
            q_smp_q   <= q_smp_d;
            checked_q <= checked_d;
            errcnt_q  <= errcnt_d;
            first_q   <= first_d;
            err_q     <= err_d;
            pulse_q   <= pulse_d;
        end
    end

    assign checked_cnt   = checked_q;
    assign err_cnt       = errcnt_q;
    assign first_err_idx = first_q;
    assign err           = err_q;
    assign err_pulse     = pulse_q;
    assign synced        = (state_q == ST_CHECK);

endmodule
